// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : ex_stage
// Description : RV32I execute stage. Operand forwarding, ALU, branch/jump
//               resolution, EX/MEM pipeline register and a registered
//               one-cycle fetch redirect with wrong-path squash.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_ex_valid,
    input  logic [XLEN-1:0] id_ex_pc,
    input  logic [XLEN-1:0] id_ex_rs1_val,
    input  logic [XLEN-1:0] id_ex_rs2_val,
    input  logic [XLEN-1:0] id_ex_imm,
    input  logic [4:0]      id_ex_rd,
    input  logic [3:0]      id_ex_alu_op,
    input  logic            id_ex_alu_src,
    input  logic [2:0]      id_ex_br_type,
    input  logic            id_ex_jalr,
    input  logic            id_ex_reg_write,
    input  logic            id_ex_mem_read,
    input  logic            id_ex_mem_write,
    input  logic [1:0]      fwd_a,
    input  logic [1:0]      fwd_b,
    input  logic [XLEN-1:0] mem_fwd_val,
    input  logic [XLEN-1:0] wb_fwd_val,
    input  logic            stall,
    output logic            ex_mem_valid,
    output logic [XLEN-1:0] ex_mem_alu_result,
    output logic [XLEN-1:0] ex_mem_store_data,
    output logic [4:0]      ex_mem_rd,
    output logic            ex_mem_reg_write,
    output logic            ex_mem_mem_read,
    output logic            ex_mem_mem_write,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);

    localparam logic [3:0] c_OP_ADD  = 4'd0;
    localparam logic [3:0] c_OP_SUB  = 4'd1;
    localparam logic [3:0] c_OP_SLL  = 4'd2;
    localparam logic [3:0] c_OP_SLT  = 4'd3;
    localparam logic [3:0] c_OP_SLTU = 4'd4;
    localparam logic [3:0] c_OP_XOR  = 4'd5;
    localparam logic [3:0] c_OP_SRL  = 4'd6;
    localparam logic [3:0] c_OP_SRA  = 4'd7;
    localparam logic [3:0] c_OP_OR   = 4'd8;
    localparam logic [3:0] c_OP_AND  = 4'd9;
    localparam logic [3:0] c_OP_LUI  = 4'd10;
    localparam logic [3:0] c_OP_AUI  = 4'd11;
    localparam logic [3:0] c_OP_LINK = 4'd12;

    logic [XLEN-1:0] w_op_a;
    logic [XLEN-1:0] w_rs2;
    logic [XLEN-1:0] w_op_b;
    logic [XLEN-1:0] w_alu;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_jalr_sum;
    logic            w_taken;
    logic            w_effective;
    logic            w_redirect;
    logic            kill_q;
    logic            kill_d;

    // Forwarding muxes; selects 0 and 3 both take the ID/EX value
    always_comb begin
        w_op_a = id_ex_rs1_val;
        w_rs2  = id_ex_rs2_val;
        case (fwd_a)
            2'd1:    w_op_a = mem_fwd_val;
            2'd2:    w_op_a = wb_fwd_val;
            default: w_op_a = id_ex_rs1_val;
        endcase
        case (fwd_b)
            2'd1:    w_rs2 = mem_fwd_val;
            2'd2:    w_rs2 = wb_fwd_val;
            default: w_rs2 = id_ex_rs2_val;
        endcase
        w_op_b = id_ex_alu_src ? id_ex_imm : w_rs2;
    end

    // ALU; unused opcodes 13-15 yield zero
    always_comb begin
        w_alu = '0;
        case (id_ex_alu_op)
            c_OP_ADD:  w_alu = w_op_a + w_op_b;
            c_OP_SUB:  w_alu = w_op_a - w_op_b;
            c_OP_SLL:  w_alu = w_op_a << w_op_b[4:0];
            c_OP_SLT:  w_alu = {{(XLEN-1){1'b0}}, $signed(w_op_a) < $signed(w_op_b)};
            c_OP_SLTU: w_alu = {{(XLEN-1){1'b0}}, w_op_a < w_op_b};
            c_OP_XOR:  w_alu = w_op_a ^ w_op_b;
            c_OP_SRL:  w_alu = w_op_a >> w_op_b[4:0];
            c_OP_SRA:  w_alu = $unsigned($signed(w_op_a) >>> w_op_b[4:0]);
            c_OP_OR:   w_alu = w_op_a | w_op_b;
            c_OP_AND:  w_alu = w_op_a & w_op_b;
            c_OP_LUI:  w_alu = w_op_b;
            c_OP_AUI:  w_alu = id_ex_pc + w_op_b;
            c_OP_LINK: w_alu = id_ex_pc + 32'd4;
            default:   w_alu = '0;
        endcase
    end

    // Branch condition uses forwarded rs1/rs2 (never the immediate) and target select
    always_comb begin
        w_taken = 1'b0;
        case (id_ex_br_type)
            3'd1:    w_taken = (w_op_a == w_rs2);
            3'd2:    w_taken = (w_op_a != w_rs2);
            3'd3:    w_taken = ($signed(w_op_a) <  $signed(w_rs2));
            3'd4:    w_taken = ($signed(w_op_a) >= $signed(w_rs2));
            3'd5:    w_taken = (w_op_a <  w_rs2);
            3'd6:    w_taken = (w_op_a >= w_rs2);
            3'd7:    w_taken = 1'b1;
            default: w_taken = 1'b0;
        endcase
        w_jalr_sum = w_op_a + id_ex_imm;
        if (id_ex_br_type == 3'd7 && id_ex_jalr) begin
            w_target = {w_jalr_sum[XLEN-1:1], 1'b0};
        end else begin
            w_target = id_ex_pc + id_ex_imm;
        end
    end

    assign w_effective = id_ex_valid && !kill_q;
    assign w_redirect  = w_effective && w_taken;
    // Kill is armed by a captured redirect, cleared by the next consuming edge
    assign kill_d      = stall ? kill_q : w_redirect;

    // EX/MEM pipeline register, redirect pulse and kill flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_mem_valid      <= 1'b0;
            ex_mem_alu_result <= '0;
            ex_mem_store_data <= '0;
            ex_mem_rd         <= '0;
            ex_mem_reg_write  <= 1'b0;
            ex_mem_mem_read   <= 1'b0;
            ex_mem_mem_write  <= 1'b0;
            redirect_valid    <= 1'b0;
            redirect_pc       <= '0;
            kill_q            <= 1'b0;
        end else begin
            kill_q <= kill_d;
            if (stall) begin
                redirect_valid <= 1'b0;
            end else begin
                ex_mem_valid      <= w_effective;
                ex_mem_alu_result <= w_alu;
                ex_mem_store_data <= w_rs2;
                ex_mem_rd         <= id_ex_rd;
                ex_mem_reg_write  <= id_ex_reg_write && w_effective;
                ex_mem_mem_read   <= id_ex_mem_read  && w_effective;
                ex_mem_mem_write  <= id_ex_mem_write && w_effective;
                redirect_valid    <= w_redirect;
                if (w_redirect) begin
                    redirect_pc <= w_target;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_stage
// Description : Directed self-checking bench for ex_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_ex_valid;
    logic [31:0] id_ex_pc, id_ex_rs1_val, id_ex_rs2_val, id_ex_imm;
    logic [4:0]  id_ex_rd;
    logic [3:0]  id_ex_alu_op;
    logic        id_ex_alu_src;
    logic [2:0]  id_ex_br_type;
    logic        id_ex_jalr, id_ex_reg_write, id_ex_mem_read, id_ex_mem_write;
    logic [1:0]  fwd_a, fwd_b;
    logic [31:0] mem_fwd_val, wb_fwd_val;
    logic        stall;
    logic        ex_mem_valid;
    logic [31:0] ex_mem_alu_result, ex_mem_store_data;
    logic [4:0]  ex_mem_rd;
    logic        ex_mem_reg_write, ex_mem_mem_read, ex_mem_mem_write;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ex_stage #(.XLEN(32)) dut (
        .clk(clk), .reset(reset),
        .id_ex_valid(id_ex_valid), .id_ex_pc(id_ex_pc),
        .id_ex_rs1_val(id_ex_rs1_val), .id_ex_rs2_val(id_ex_rs2_val),
        .id_ex_imm(id_ex_imm), .id_ex_rd(id_ex_rd),
        .id_ex_alu_op(id_ex_alu_op), .id_ex_alu_src(id_ex_alu_src),
        .id_ex_br_type(id_ex_br_type), .id_ex_jalr(id_ex_jalr),
        .id_ex_reg_write(id_ex_reg_write), .id_ex_mem_read(id_ex_mem_read),
        .id_ex_mem_write(id_ex_mem_write),
        .fwd_a(fwd_a), .fwd_b(fwd_b),
        .mem_fwd_val(mem_fwd_val), .wb_fwd_val(wb_fwd_val),
        .stall(stall),
        .ex_mem_valid(ex_mem_valid), .ex_mem_alu_result(ex_mem_alu_result),
        .ex_mem_store_data(ex_mem_store_data), .ex_mem_rd(ex_mem_rd),
        .ex_mem_reg_write(ex_mem_reg_write), .ex_mem_mem_read(ex_mem_mem_read),
        .ex_mem_mem_write(ex_mem_mem_write),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    // Put an ALU instruction with default controls in the ID/EX slot
    task automatic set_alu(input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic src, input logic [31:0] imm);
        id_ex_valid = 1'b1;    id_ex_pc = 32'h0;       id_ex_rs1_val = a;
        id_ex_rs2_val = b;     id_ex_imm = imm;        id_ex_rd = 5'd1;
        id_ex_alu_op = op;     id_ex_alu_src = src;    id_ex_br_type = 3'd0;
        id_ex_jalr = 1'b0;     id_ex_reg_write = 1'b1; id_ex_mem_read = 1'b0;
        id_ex_mem_write = 1'b0; fwd_a = 2'd0;          fwd_b = 2'd0;
        mem_fwd_val = 32'h0;   wb_fwd_val = 32'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        set_alu(4'd0, 32'd0, 32'd0, 1'b0, 32'd0);
        id_ex_valid = 1'b0;
        stall = 1'b0;
        reset = 1'b1;
        tick(); tick();
        n_cmp++; if (ex_mem_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", ex_mem_valid); end
        n_cmp++; if (ex_mem_alu_result !== 32'h0) begin n_err++; $display("FAIL reset_result got %h want 0", ex_mem_alu_result); end
        n_cmp++; if (redirect_valid !== 1'b0 || redirect_pc !== 32'h0) begin n_err++; $display("FAIL reset_redirect got %b/%h want 0/0", redirect_valid, redirect_pc); end
        n_cmp++; if ({ex_mem_reg_write, ex_mem_mem_read, ex_mem_mem_write} !== 3'b000) begin n_err++; $display("FAIL reset_ctrl got %b want 000", {ex_mem_reg_write, ex_mem_mem_read, ex_mem_mem_write}); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_alu();
        set_alu(4'd0, 32'd5, 32'd7, 1'b0, 32'd0); tick();
        n_cmp++; if (ex_mem_alu_result !== 32'd12 || ex_mem_valid !== 1'b1 || redirect_valid !== 1'b0) begin n_err++; $display("FAIL add got %h v%b r%b want 0000000c v1 r0", ex_mem_alu_result, ex_mem_valid, redirect_valid); end
        set_alu(4'd7, 32'h80000000, 32'd0, 1'b1, 32'd4); tick();
        n_cmp++; if (ex_mem_alu_result !== 32'hF8000000) begin n_err++; $display("FAIL sra got %h want f8000000", ex_mem_alu_result); end
        set_alu(4'd4, 32'd1, 32'hFFFFFFFF, 1'b0, 32'd0); tick();
        n_cmp++; if (ex_mem_alu_result !== 32'd1) begin n_err++; $display("FAIL sltu got %h want 1", ex_mem_alu_result); end
        set_alu(4'd3, 32'd1, 32'hFFFFFFFF, 1'b0, 32'd0); tick();
        n_cmp++; if (ex_mem_alu_result !== 32'd0) begin n_err++; $display("FAIL slt got %h want 0", ex_mem_alu_result); end
        set_alu(4'd1, 32'd0, 32'd1, 1'b0, 32'd0); tick();
        n_cmp++; if (ex_mem_alu_result !== 32'hFFFFFFFF) begin n_err++; $display("FAIL sub_wrap got %h want ffffffff", ex_mem_alu_result); end
        set_alu(4'd6, 32'h80000000, 32'd0, 1'b1, 32'd36); tick();
        n_cmp++; if (ex_mem_alu_result !== 32'h08000000) begin n_err++; $display("FAIL srl_shamt got %h want 08000000", ex_mem_alu_result); end
        set_alu(4'd11, 32'd0, 32'd0, 1'b1, 32'h1000); id_ex_pc = 32'h100; tick();
        n_cmp++; if (ex_mem_alu_result !== 32'h1100) begin n_err++; $display("FAIL auipc got %h want 00001100", ex_mem_alu_result); end
        set_alu(4'd5, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 32'd0); tick();
        n_cmp++; if (ex_mem_alu_result !== 32'h0FF00FF0) begin n_err++; $display("FAIL xor got %h want 0ff00ff0", ex_mem_alu_result); end
        set_alu(4'd14, 32'd3, 32'd4, 1'b0, 32'd0); tick();
        n_cmp++; if (ex_mem_alu_result !== 32'h0) begin n_err++; $display("FAIL op14 got %h want 0", ex_mem_alu_result); end
    endtask

    task automatic test_forward();
        set_alu(4'd0, 32'd999, 32'd0, 1'b1, 32'hFFFFFFFC);
        fwd_a = 2'd1; mem_fwd_val = 32'd100; tick();
        n_cmp++; if (ex_mem_alu_result !== 32'd96) begin n_err++; $display("FAIL fwd_a_mem got %0d want 96", ex_mem_alu_result); end
        set_alu(4'd0, 32'h200, 32'h55, 1'b1, 32'd8);
        id_ex_reg_write = 1'b0; id_ex_mem_write = 1'b1;
        fwd_b = 2'd2; wb_fwd_val = 32'hAB; mem_fwd_val = 32'hCD; tick();
        n_cmp++; if (ex_mem_store_data !== 32'hAB || ex_mem_alu_result !== 32'h208 || ex_mem_mem_write !== 1'b1) begin n_err++; $display("FAIL fwd_b_store got %h/%h/%b want ab/208/1", ex_mem_store_data, ex_mem_alu_result, ex_mem_mem_write); end
        set_alu(4'd0, 32'd10, 32'd20, 1'b0, 32'd0);
        fwd_a = 2'd3; fwd_b = 2'd3; mem_fwd_val = 32'd1000; wb_fwd_val = 32'd2000; tick();
        n_cmp++; if (ex_mem_alu_result !== 32'd30) begin n_err++; $display("FAIL fwd_sel3 got %0d want 30", ex_mem_alu_result); end
    endtask

    task automatic test_branch();
        set_alu(4'd0, 32'd9, 32'd9, 1'b0, 32'h20);
        id_ex_pc = 32'h40; id_ex_br_type = 3'd1; id_ex_reg_write = 1'b0; tick();
        n_cmp++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h60) begin n_err++; $display("FAIL beq_redirect got %b/%h want 1/60", redirect_valid, redirect_pc); end
        set_alu(4'd0, 32'd1, 32'd2, 1'b0, 32'd0); id_ex_rd = 5'd3; tick();
        n_cmp++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL beq_pulse_len got %b want 0", redirect_valid); end
        n_cmp++; if (ex_mem_valid !== 1'b0 || ex_mem_reg_write !== 1'b0) begin n_err++; $display("FAIL squash got v%b rw%b want v0 rw0", ex_mem_valid, ex_mem_reg_write); end
        set_alu(4'd0, 32'd1, 32'd2, 1'b0, 32'd0); id_ex_rd = 5'd4; tick();
        n_cmp++; if (ex_mem_valid !== 1'b1 || ex_mem_reg_write !== 1'b1 || ex_mem_rd !== 5'd4 || ex_mem_alu_result !== 32'd3) begin n_err++; $display("FAIL post_squash got v%b rw%b rd%0d res%0d want v1 rw1 rd4 res3", ex_mem_valid, ex_mem_reg_write, ex_mem_rd, ex_mem_alu_result); end
        set_alu(4'd0, 32'd9, 32'd9, 1'b0, 32'h100); id_ex_pc = 32'h200; id_ex_br_type = 3'd2; tick();
        n_cmp++; if (redirect_valid !== 1'b0 || redirect_pc !== 32'h60) begin n_err++; $display("FAIL bne_not_taken got %b/%h want 0/60", redirect_valid, redirect_pc); end
        set_alu(4'd0, 32'd1, 32'hFFFFFFFF, 1'b1, 32'd1); id_ex_pc = 32'h200; id_ex_br_type = 3'd6; tick();
        n_cmp++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL bgeu_not_taken got %b want 0", redirect_valid); end
        set_alu(4'd0, 32'hFFFFFFFF, 32'd1, 1'b1, 32'hFFFFFFF0); id_ex_pc = 32'h200; id_ex_br_type = 3'd3; tick();
        n_cmp++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1F0) begin n_err++; $display("FAIL blt_taken got %b/%h want 1/1f0", redirect_valid, redirect_pc); end
        set_alu(4'd0, 32'd0, 32'd0, 1'b0, 32'd0); tick();
        set_alu(4'd0, 32'd0, 32'd0, 1'b0, 32'd0); tick();
    endtask

    task automatic test_jalr_stall();
        set_alu(4'd12, 32'h1001, 32'd0, 1'b1, 32'd2);
        id_ex_pc = 32'h80; id_ex_br_type = 3'd7; id_ex_jalr = 1'b1; tick();
        n_cmp++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1002 || ex_mem_alu_result !== 32'h84) begin n_err++; $display("FAIL jalr got %b/%h/%h want 1/1002/84", redirect_valid, redirect_pc, ex_mem_alu_result); end
        set_alu(4'd0, 32'd7, 32'd7, 1'b0, 32'd0); id_ex_rd = 5'd5; stall = 1'b1; tick();
        n_cmp++; if (redirect_valid !== 1'b0 || ex_mem_valid !== 1'b1 || ex_mem_alu_result !== 32'h84) begin n_err++; $display("FAIL stall_hold1 got r%b v%b res%h want r0 v1 res84", redirect_valid, ex_mem_valid, ex_mem_alu_result); end
        tick();
        n_cmp++; if (redirect_valid !== 1'b0 || ex_mem_alu_result !== 32'h84 || redirect_pc !== 32'h1002) begin n_err++; $display("FAIL stall_hold2 got r%b res%h pc%h want r0 res84 pc1002", redirect_valid, ex_mem_alu_result, redirect_pc); end
        stall = 1'b0; tick();
        n_cmp++; if (ex_mem_valid !== 1'b0 || ex_mem_reg_write !== 1'b0) begin n_err++; $display("FAIL stall_squash got v%b rw%b want v0 rw0", ex_mem_valid, ex_mem_reg_write); end
        set_alu(4'd0, 32'd7, 32'd7, 1'b0, 32'd0); tick();
        n_cmp++; if (ex_mem_valid !== 1'b1 || ex_mem_alu_result !== 32'd14) begin n_err++; $display("FAIL after_stall got v%b res%0d want v1 res14", ex_mem_valid, ex_mem_alu_result); end
    endtask

    task automatic test_reset_mid();
        set_alu(4'd0, 32'd9, 32'd9, 1'b0, 32'h20);
        id_ex_pc = 32'h40; id_ex_br_type = 3'd1; tick();
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (ex_mem_valid !== 1'b0 || redirect_valid !== 1'b0 || redirect_pc !== 32'h0 || ex_mem_alu_result !== 32'h0) begin n_err++; $display("FAIL async_reset got v%b r%b pc%h res%h want all 0", ex_mem_valid, redirect_valid, redirect_pc, ex_mem_alu_result); end
        #1 reset = 1'b0;
        set_alu(4'd0, 32'd2, 32'd3, 1'b0, 32'd0); tick();
        n_cmp++; if (ex_mem_valid !== 1'b1 || ex_mem_reg_write !== 1'b1 || ex_mem_alu_result !== 32'd5) begin n_err++; $display("FAIL post_reset got v%b rw%b res%0d want v1 rw1 res5", ex_mem_valid, ex_mem_reg_write, ex_mem_alu_result); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_forward();
        test_branch();
        test_jalr_stall();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ex_stage.md
# ex_stage

Execute stage of the RV32I 5-stage pipeline, directly downstream of the ID/EX pipeline register. It applies operand forwarding, runs the ALU, resolves branches and jumps, and captures results into the EX/MEM pipeline register for the memory stage. Taken control transfers produce a registered one-cycle redirect to the fetch stage. The block also squashes the wrong-path instruction that follows a redirect.

## Interface
Parameters:
- `XLEN`, 32, datapath width; only 32 is supported.

Ports:
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high.
- `id_ex_valid` in 1: the ID/EX slot holds a real instruction.
- `id_ex_pc` in 32: PC of the instruction.
- `id_ex_rs1_val`, `id_ex_rs2_val` in 32 each: register-file operands.
- `id_ex_imm` in 32: sign-extended immediate.
- `id_ex_rd` in 5: destination register.
- `id_ex_alu_op` in 4: ALU operation (see Operation).
- `id_ex_alu_src` in 1: 1 selects the immediate as ALU B; 0 selects forwarded rs2.
- `id_ex_br_type` in 3: 0 none, 1 BEQ, 2 BNE, 3 BLT, 4 BGE, 5 BLTU, 6 BGEU, 7 JUMP.
- `id_ex_jalr` in 1: for JUMP, 1 selects the rs1+imm target; 0 selects pc+imm.
- `id_ex_reg_write`, `id_ex_mem_read`, `id_ex_mem_write` in 1 each: control bits passed downstream.
- `fwd_a`, `fwd_b` in 2 each: operand source. 0 = ID/EX value, 1 = `mem_fwd_val`, 2 = `wb_fwd_val`, 3 = ID/EX value.
- `mem_fwd_val`, `wb_fwd_val` in 32 each: forwarded results.
- `stall` in 1: hold EX/MEM and do not consume the EX instruction.
- `ex_mem_valid` out 1, `ex_mem_alu_result` out 32, `ex_mem_store_data` out 32, `ex_mem_rd` out 5, `ex_mem_reg_write` out 1, `ex_mem_mem_read` out 1, `ex_mem_mem_write` out 1: EX/MEM register contents.
- `redirect_valid` out 1: registered one-cycle pulse requesting a PC change.
- `redirect_pc` out 32: redirect target.

## Operation
- Operands:
  - A = forwarded rs1 per `fwd_a`.
  - Fwd rs2 = forwarded rs2 per `fwd_b`.
  - B = `id_ex_imm` if `id_ex_alu_src`, else fwd rs2.
- ALU ops:
  - 0 ADD, 1 SUB.
  - 2 SLL, 6 SRL, 7 SRA: shift amount is B[4:0].
  - 3 SLT (signed), 4 SLTU: result is 0 or 1.
  - 5 XOR, 8 OR, 9 AND.
  - 10 pass B (LUI), 11 pc+B (AUIPC), 12 pc+4 (link).
  - 13–15 produce 0.
  - All arithmetic wraps modulo 2^32.
- Branch compare always uses forwarded rs1 vs forwarded rs2, never the immediate.
  - Taken = condition true for types 1–6; always true for type 7.
- Targets:
  - Conditional branch and JAL: pc+imm.
  - JALR: (A+imm) with bit 0 cleared.
  - No misalignment trap; bit 1 passes through.
- Internal `kill` flag: an instruction is effective when `id_ex_valid && !kill`.
- Capture when `stall`=0:
  - The EX/MEM register loads the effective instruction's results. `ex_mem_valid` = effective.
  - `ex_mem_store_data` = fwd rs2.
  - Control bits are forced to 0 when the instruction is not effective.
  - `redirect_valid` <= effective && taken. `redirect_pc` <= target when taken, otherwise holds.
- Hold when `stall`=1:
  - All EX/MEM outputs hold.
  - `redirect_valid` <= 0, so a pulse never lasts more than one cycle.
- Kill flag:
  - Set on any cycle where a redirect is captured.
  - Otherwise cleared on the first non-stalled cycle after it was set. This squashes exactly one subsequent instruction, the wrong-path instruction already in EX when the pulse is seen.
- Kill and stall together: kill stays set across stall cycles until that instruction is consumed.
- Upstream is responsible for flushing IF/ID and ID/EX on `redirect_valid`.

## Timing
- Latency: the instruction in EX at edge N appears on the EX/MEM outputs after edge N (1 cycle). `redirect_valid` is asserted in the same cycle as the EX/MEM capture.
- Reset (asynchronous, immediate): all EX/MEM outputs 0, `redirect_valid` 0, `redirect_pc` 0, `kill` 0.
- Reset mid-stall or mid-kill discards all state; the first post-reset instruction is effective.
- Forwarding select inputs and operand values are sampled at the capturing edge only.

## Test plan
- ADD, rs1=5, rs2=7, no stall -> next cycle `ex_mem_alu_result`=12, `ex_mem_valid`=1, `redirect_valid`=0.
- SRA, A=0x80000000, imm=4, alu_src=1 -> result 0xF8000000; SLTU with 1 vs 0xFFFFFFFF -> 1; SLT with the same operands -> 0.
- `fwd_a`=1, `mem_fwd_val`=100, imm=-4, ADD with alu_src=1 -> result 96; `fwd_b`=2, `wb_fwd_val`=0xAB on a store -> `ex_mem_store_data`=0xAB.
- BEQ at pc 0x40, imm 0x20, equal operands -> `redirect_valid`=1 for exactly one cycle, `redirect_pc`=0x60. Next instruction (ADD, rd=3, reg_write=1) -> captured with `ex_mem_valid`=0 and `reg_write`=0. The instruction after that is effective.
- JALR, A=0x1001, imm=2, alu_op=12, pc=0x80 -> `redirect_pc`=0x1002, `ex_mem_alu_result`=0x84. Assert `stall` for 2 cycles in the pulse cycle -> pulse still lasts 1 cycle, and the held wrong-path instruction is squashed when stall drops.
- `reset` asserted mid-cycle while `ex_mem_valid`=1 and `kill`=1 -> outputs 0 immediately, no clock edge needed. After release, the first valid instruction is captured as effective.
